// File: rtl/mmio_bus_ctl.sv
// Registered LC-3 memory/IO decoder: classifies the captured address, runs the
// access FSM and returns R with BUS_ERR, device strobes and the read-mux select.
module mmio_bus_ctl #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] BASE     = 16'h7E00,
  parameter int                STRIDE   = 2,
  parameter int                N_DEV    = 10,
  parameter int                MEM_WAIT = 2,
  parameter logic [N_DEV-1:0]  RO_MASK  = 10'b0010000010,
  parameter int                SEL_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] MAR,
  input  logic              R_W,
  input  logic              MIO_EN,
  output logic              MEM_EN,
  output logic [N_DEV-1:0]  LD_DEV,
  output logic [SEL_W-1:0]  INMUX_Sel,
  output logic              R,
  output logic              BUS_ERR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {CLS_MEM, CLS_DEV, CLS_UNM} cls_t;

  // One extra bit so a window reaching the top of the address space does not wrap.
  localparam logic [ADDR_W:0] BASE_X    = {1'b0, BASE};
  localparam logic [ADDR_W:0] WIN_END   = BASE_X + (ADDR_W+1)'(N_DEV * STRIDE);
  localparam logic [3:0]      WAIT_LAST = 4'(MEM_WAIT);

  logic [N_DEV-1:0] hit;
  logic             in_win;
  cls_t             dec_cls;
  logic [SEL_W-1:0] dec_sel;

  state_t           state;
  cls_t             cls;
  logic             wr;
  logic [N_DEV-1:0] slot_hot;
  logic [3:0]       wait_cnt;
  logic             acc_err;
  logic [N_DEV-1:0] acc_ld;

  assign in_win = ({1'b0, MAR} >= BASE_X) && ({1'b0, MAR} < WIN_END);

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_slot
    localparam logic [ADDR_W:0] SLOT_ADDR = BASE_X + (ADDR_W+1)'(gi * STRIDE);
    assign hit[gi]    = ({1'b0, MAR} == SLOT_ADDR);
    assign acc_ld[gi] = (cls == CLS_DEV) && wr && slot_hot[gi] && !RO_MASK[gi];
  end

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (hit[i]) dec_sel = SEL_W'(i + 1);
    end
  end

  // An in-window address that matches no slot is a misaligned (unmapped) hole.
  always_comb begin
    if (!in_win)   dec_cls = CLS_MEM;
    else if (|hit) dec_cls = CLS_DEV;
    else           dec_cls = CLS_UNM;
  end

  assign acc_err = (cls == CLS_UNM) ||
                   ((cls == CLS_DEV) && wr && (|(slot_hot & RO_MASK)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cls       <= CLS_MEM;
      wr        <= 1'b0;
      slot_hot  <= '0;
      wait_cnt  <= '0;
      MEM_EN    <= 1'b0;
      LD_DEV    <= '0;
      INMUX_Sel <= '0;
      R         <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      R       <= 1'b0;
      BUS_ERR <= 1'b0;
      LD_DEV  <= '0;
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            state     <= ACCESS;
            cls       <= dec_cls;
            wr        <= R_W;
            slot_hot  <= hit;
            wait_cnt  <= '0;
            MEM_EN    <= (dec_cls == CLS_MEM);
            INMUX_Sel <= R_W ? '0 : dec_sel;
          end
        end
        ACCESS: begin
          // INMUX_Sel is deliberately left alone on abort.
          if (!MIO_EN) begin
            state  <= IDLE;
            MEM_EN <= 1'b0;
          end else if ((cls != CLS_MEM) || (wait_cnt == WAIT_LAST)) begin
            state   <= DONE;
            MEM_EN  <= 1'b0;
            R       <= 1'b1;
            BUS_ERR <= acc_err;
            LD_DEV  <= acc_ld;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
